// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arb_pkg
// Description : Shared state encoding and sizing constants for arb_rr_4.
// Revision    : 1.0 - initial release
// ============================================================================
package arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int N_REQ  = 4;
    localparam int ID_W   = 2;
    localparam int HOLD_W = 8;

endpackage : arb_pkg
`default_nettype wire

// File: rtl/dec_2_4_hl.sv
`default_nettype none
// ============================================================================
// Module      : dec_2_4_hl
// Description : 2-to-4 one-hot decoder with enable and output polarity.
// Revision    : 1.0 - initial release
// ============================================================================
module dec_2_4_hl (
    input  logic       HL,
    input  logic       EN,
    input  logic [1:0] IN,
    output logic [3:0] OUT
);

    logic [3:0] onehot;

    always_comb begin
        onehot = 4'b0000;
        if (EN) begin
            case (IN)
                2'd0:    onehot = 4'b0001;
                2'd1:    onehot = 4'b0010;
                2'd2:    onehot = 4'b0100;
                2'd3:    onehot = 4'b1000;
                default: onehot = 4'b0000;
            endcase
        end
        OUT = HL ? onehot : ~onehot;
    end

endmodule : dec_2_4_hl
`default_nettype wire

// File: rtl/arb_rr_4.sv
`default_nettype none
// ============================================================================
// Module      : arb_rr_4
// Description : Four-requester round-robin arbiter with hold limit and
//               polarity-selectable one-hot grant.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_rr_4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 15
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             HL,
    input  logic [N_REQ-1:0] REQ,
    input  logic             DONE,
    output logic [N_REQ-1:0] GNT,
    output logic [ID_W-1:0]  GNT_ID,
    output logic             GNT_VALID,
    output logic             TIMEOUT
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_t             state, state_n;
    logic [ID_W-1:0]    ptr, ptr_n;
    logic [ID_W-1:0]    id, id_n;
    logic [HOLD_W-1:0]  hold_cnt, hold_cnt_n;
    logic               timeout_q, timeout_n;

    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   req_rot;
    logic [ID_W-1:0]    pri_idx;
    logic [ID_W-1:0]    winner;

    // Rotate so ptr sits at bit 0, take the lowest set bit, rotate back.
    always_comb begin
        req_dbl = {REQ, REQ};
        req_rot = N_REQ'(req_dbl >> ptr);
        pri_idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) pri_idx = ID_W'(k);
        end
        winner = ptr + pri_idx;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            ptr       <= '0;
            id        <= '0;
            hold_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            id        <= id_n;
            hold_cnt  <= hold_cnt_n;
            timeout_q <= timeout_n;
        end
    end

    // Release priority: EN drop first, then DONE / request drop, then hold limit.
    always_comb begin
        state_n    = state;
        ptr_n      = ptr;
        id_n       = id;
        hold_cnt_n = hold_cnt;
        timeout_n  = 1'b0;
        case (state)
            IDLE: begin
                if (EN && (|REQ)) begin
                    state_n    = GRANT;
                    id_n       = winner;
                    hold_cnt_n = '0;
                end
            end
            GRANT: begin
                if (!EN) begin
                    state_n = IDLE;
                end else if (DONE || !REQ[id]) begin
                    state_n = IDLE;
                    ptr_n   = id + ID_W'(1);
                end else if (hold_cnt == HOLD_LAST) begin
                    state_n   = IDLE;
                    ptr_n     = id + ID_W'(1);
                    timeout_n = 1'b1;
                end else begin
                    hold_cnt_n = hold_cnt + HOLD_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign GNT_VALID = (state == GRANT);
    assign GNT_ID    = id;
    assign TIMEOUT   = timeout_q;

    dec_2_4_hl u_dec (
        .HL  (HL),
        .EN  (GNT_VALID),
        .IN  (id),
        .OUT (GNT)
    );

endmodule : arb_rr_4
`default_nettype wire

// File: tb/tb_arb_rr_4.sv
`default_nettype none
// ============================================================================
// Module      : tb_arb_rr_4
// Description : Self-checking bench for arb_rr_4 (vector table, corner
//               sequences and randomized run against a reference model).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arb_rr_4;

    localparam int MAX_HOLD = 15;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       EN = 1'b0;
    logic       HL = 1'b1;
    logic [3:0] REQ = 4'b0000;
    logic       DONE = 1'b0;
    logic [3:0] GNT;
    logic [1:0] GNT_ID;
    logic       GNT_VALID;
    logic       TIMEOUT;

    int n_cmp = 0;
    int n_fail = 0;

    arb_rr_4 #(.MAX_HOLD(MAX_HOLD)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .EN        (EN),
        .HL        (HL),
        .REQ       (REQ),
        .DONE      (DONE),
        .GNT       (GNT),
        .GNT_ID    (GNT_ID),
        .GNT_VALID (GNT_VALID),
        .TIMEOUT   (TIMEOUT)
    );

    always #5 CLK = ~CLK;

    // Reference model: who holds the resource, for how many cycles so far,
    // and where the next search begins.
    bit m_busy = 1'b0;
    int m_holder = 0;
    int m_start = 0;
    int m_served = 0;
    bit m_to = 1'b0;

    task automatic model_edge();
        bit to_next;
        to_next = 1'b0;
        if (RST) begin
            m_busy = 1'b0; m_holder = 0; m_start = 0; m_served = 0;
        end else if (!m_busy) begin
            if (EN && REQ != 4'b0000) begin
                for (int k = 0; k < 4; k++) begin
                    if (REQ[(m_start + k) % 4]) begin
                        m_holder = (m_start + k) % 4;
                        break;
                    end
                end
                m_busy = 1'b1;
                m_served = 1;
            end
        end else if (!EN) begin
            m_busy = 1'b0;
        end else if (DONE || !REQ[m_holder]) begin
            m_busy = 1'b0;
            m_start = (m_holder + 1) % 4;
        end else if (m_served == MAX_HOLD) begin
            m_busy = 1'b0;
            m_start = (m_holder + 1) % 4;
            to_next = 1'b1;
        end else begin
            m_served++;
        end
        m_to = to_next;
    endtask

    function automatic logic [3:0] model_gnt();
        logic [3:0] oh;
        oh = 4'b0000;
        if (m_busy) oh[m_holder] = 1'b1;
        return HL ? oh : ~oh;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".gnt"},     32'(GNT),       32'(model_gnt()));
        chk({tag, ".gnt_id"},  32'(GNT_ID),    32'(m_holder));
        chk({tag, ".valid"},   32'(GNT_VALID), 32'(m_busy));
        chk({tag, ".timeout"}, 32'(TIMEOUT),   32'(m_to));
    endtask

    task automatic do_reset();
        RST = 1'b1; DONE = 1'b0;
        step();
        RST = 1'b0;
    endtask

    typedef struct {
        logic       rst, en, hl;
        logic [3:0] req;
        logic       done;
        logic [3:0] gnt;
        logic [1:0] id;
        logic       valid, to;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int cnt;
        // rst en hl req done | gnt id valid timeout (after the edge)
        tbl.push_back('{1'b1,1'b1,1'b1,4'b1111,1'b0, 4'b0000,2'd0,1'b0,1'b0});
        tbl.push_back('{1'b1,1'b1,1'b0,4'b1111,1'b0, 4'b1111,2'd0,1'b0,1'b0});
        tbl.push_back('{1'b0,1'b1,1'b1,4'b0100,1'b0, 4'b0100,2'd2,1'b1,1'b0});
        tbl.push_back('{1'b0,1'b1,1'b1,4'b0100,1'b0, 4'b0100,2'd2,1'b1,1'b0});
        tbl.push_back('{1'b0,1'b1,1'b1,4'b0100,1'b0, 4'b0100,2'd2,1'b1,1'b0});
        tbl.push_back('{1'b0,1'b1,1'b1,4'b0100,1'b1, 4'b0000,2'd2,1'b0,1'b0});
        tbl.push_back('{1'b0,1'b1,1'b1,4'b1111,1'b0, 4'b1000,2'd3,1'b1,1'b0});
        tbl.push_back('{1'b0,1'b1,1'b0,4'b1001,1'b0, 4'b0111,2'd3,1'b1,1'b0});
        tbl.push_back('{1'b0,1'b1,1'b0,4'b1001,1'b1, 4'b1111,2'd3,1'b0,1'b0});
        tbl.push_back('{1'b0,1'b1,1'b0,4'b1001,1'b0, 4'b1110,2'd0,1'b1,1'b0});
        tbl.push_back('{1'b0,1'b1,1'b1,4'b1111,1'b1, 4'b0000,2'd0,1'b0,1'b0});
        tbl.push_back('{1'b0,1'b1,1'b1,4'b1111,1'b0, 4'b0010,2'd1,1'b1,1'b0});
        tbl.push_back('{1'b0,1'b1,1'b1,4'b1111,1'b1, 4'b0000,2'd1,1'b0,1'b0});
        tbl.push_back('{1'b0,1'b1,1'b1,4'b1111,1'b0, 4'b0100,2'd2,1'b1,1'b0});
        tbl.push_back('{1'b0,1'b0,1'b1,4'b1111,1'b0, 4'b0000,2'd2,1'b0,1'b0});
        tbl.push_back('{1'b0,1'b0,1'b1,4'b1111,1'b0, 4'b0000,2'd2,1'b0,1'b0});
        tbl.push_back('{1'b0,1'b1,1'b1,4'b1111,1'b0, 4'b0100,2'd2,1'b1,1'b0});
        tbl.push_back('{1'b0,1'b0,1'b1,4'b1111,1'b1, 4'b0000,2'd2,1'b0,1'b0});
        tbl.push_back('{1'b0,1'b1,1'b1,4'b1111,1'b0, 4'b0100,2'd2,1'b1,1'b0});

        #2;
        foreach (tbl[i]) begin
            RST = tbl[i].rst; EN = tbl[i].en; HL = tbl[i].hl;
            REQ = tbl[i].req; DONE = tbl[i].done;
            step();
            chk($sformatf("vec%0d.gnt", i),     32'(GNT),       32'(tbl[i].gnt));
            chk($sformatf("vec%0d.gnt_id", i),  32'(GNT_ID),    32'(tbl[i].id));
            chk($sformatf("vec%0d.valid", i),   32'(GNT_VALID), 32'(tbl[i].valid));
            chk($sformatf("vec%0d.timeout", i), 32'(TIMEOUT),   32'(tbl[i].to));
        end

        // Asynchronous reset while requester 2 holds the grant.
        DONE = 1'b0;
        RST = 1'b1;
        #1;
        chk("async_rst.gnt",    32'(GNT),       32'h0);
        chk("async_rst.valid",  32'(GNT_VALID), 32'h0);
        chk("async_rst.gnt_id", 32'(GNT_ID),    32'h0);
        step();
        RST = 1'b0;

        // Fairness: all requesting, DONE on each holder's second cycle.
        EN = 1'b1; HL = 1'b1; REQ = 4'b1111; DONE = 1'b0;
        for (int g = 0; g < 5; g++) begin
            step();
            chk($sformatf("fair%0d.first", g), 32'({GNT_VALID, GNT_ID}), 32'({1'b1, 2'(g % 4)}));
            step();
            chk($sformatf("fair%0d.second", g), 32'({GNT_VALID, GNT_ID}), 32'({1'b1, 2'(g % 4)}));
            DONE = 1'b1;
            step();
            chk($sformatf("fair%0d.gap", g), 32'(GNT_VALID), 32'h0);
            DONE = 1'b0;
        end

        // Timeout: requester 1 alone, no DONE.
        do_reset();
        EN = 1'b1; HL = 1'b1; REQ = 4'b0010; DONE = 1'b0;
        step();
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (!(GNT_VALID && GNT == 4'b0010)) break;
            cnt++;
            step();
        end
        chk("timeout.hold_len", 32'(cnt), 32'(MAX_HOLD));
        chk("timeout.pulse",    32'(TIMEOUT), 32'h1);
        chk("timeout.gap_gnt",  32'(GNT), 32'h0);
        step();
        chk("timeout.regrant",  32'(GNT), 32'h2);
        chk("timeout.pulse_end", 32'(TIMEOUT), 32'h0);

        // DONE on the timeout cycle: plain release, no pulse.
        do_reset();
        step();
        for (int i = 0; i < MAX_HOLD - 1; i++) step();
        chk("done_at_limit.still_held", 32'(GNT_VALID), 32'h1);
        DONE = 1'b1;
        step();
        chk("done_at_limit.released", 32'(GNT_VALID), 32'h0);
        chk("done_at_limit.no_pulse", 32'(TIMEOUT), 32'h0);
        DONE = 1'b0;

        // Randomized run against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            RST  = ($urandom_range(0, 299) == 0);
            EN   = ($urandom_range(0, 29) != 0);
            HL   = ($urandom_range(0, 9) != 0);
            DONE = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 4) == 0) REQ = 4'($urandom_range(0, 15));
            step();
            chk_model($sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_arb_rr_4
`default_nettype wire

// File: doc/arb_rr_4.md
# arb_rr_4

Four-requester round-robin arbiter that shares one downstream resource and drives its select lines through a 2-to-4 one-hot decoder with enable and output-polarity control. Each requester holds the resource until it signals `DONE`, drops its request or exceeds a hold limit. The block sits between the requesting units and the shared resource. Its grant vector uses the same `EN`/`HL` conventions as the team's decoders, so it connects directly to the resource's active-high or active-low select inputs.

## Interface
- `MAX_HOLD`, 15: maximum number of consecutive `GRANT` cycles per grant; legal range 1..255.
- `CLK`  in  1  clock; all state updates on the rising edge.
- `RST`  in  1  reset, asynchronous, active-high.
- `EN`  in  1  arbitration enable; 0 blocks new grants and revokes the current grant.
- `HL`  in  1  output polarity; 1 gives an active-high `GNT`, 0 gives an inverted `GNT`.
- `REQ`  in  4  request lines; bit i is requester i, level-sensitive.
- `DONE`  in  1  the current holder releases the resource at the next edge.
- `GNT`  out  4  one-hot grant after the polarity applied by `HL`.
- `GNT_ID`  out  2  binary index of the current or most recent holder.
- `GNT_VALID`  out  1  1 while in state `GRANT`.
- `TIMEOUT`  out  1  one-cycle pulse after a forced release caused by `MAX_HOLD`.

## Operation
- **State machine**: two states, `IDLE` and `GRANT`.
- **Internal registers**:
  - `PTR`, 2 bits: highest-priority requester.
  - `HOLD_CNT`, 8 bits.
  - `ID`, 2 bits.
- **`IDLE`**
  - If `EN`=1 and `REQ`≠0: winner = first set `REQ` bit scanning `PTR`, `PTR`+1, … modulo 4.
  - At the edge: `ID`←winner, `HOLD_CNT`←0, state→`GRANT`.
  - Otherwise stay in `IDLE`.
- **`GRANT`**: release at the edge if any of the following holds.
  - `EN`=0 → `IDLE`, `PTR` unchanged.
  - `DONE`=1 or `REQ[ID]`=0 → `IDLE`, `PTR`←`ID`+1 (mod 4, wraps 3→0).
  - `HOLD_CNT`=`MAX_HOLD`−1 → `IDLE`, `PTR`←`ID`+1, `TIMEOUT`←1 for one cycle.
  - `TIMEOUT` is set only when timeout is the sole release reason (`EN`=1, `DONE`=0, `REQ[ID]`=1).
  - Otherwise `HOLD_CNT`←`HOLD_CNT`+1.
  - Requests other than `REQ[ID]` are ignored in `GRANT`; no preemption.
- **Outputs**:
  - `GNT_VALID` = (state==`GRANT`).
  - onehot = decode(`ID`) gated by `GNT_VALID`.
  - `GNT` = `HL` ? onehot : ~onehot. `HL` acts combinationally.
- **Idle gap**: release always passes through at least one `IDLE` cycle, so two grants are never back-to-back. This guarantees a break-before-make handover.
- **Reset**: `RST`=1 forces the following immediately, regardless of `CLK`, including mid-grant.
  - State=`IDLE`, `PTR`=0, `ID`=0, `HOLD_CNT`=0, `TIMEOUT`=0.
  - Resulting outputs: `GNT_VALID`=0, `GNT_ID`=0, `GNT`=0000 (`HL`=1) or 1111 (`HL`=0).

## Timing
- **Grant latency**: `REQ` sampled at edge k in `IDLE` → `GNT` active during cycle k+1. Latency is one cycle.
- **Release latency**: `DONE` or request drop sampled at edge k → `GNT` inactive during cycle k+1. The earliest new grant is cycle k+2.
- **Hold length**: an uninterrupted grant lasts exactly `MAX_HOLD` cycles. `TIMEOUT` is high in the first `IDLE` cycle after the grant.
- **Fairness**: worst-case wait with all four requesting is 3 × (`MAX_HOLD`+1) cycles, plus one arbitration cycle.
- **Simultaneous events**:
  - `DONE` together with `EN`=0: the `EN` rule wins, so `PTR` is unchanged.
  - `DONE` on the timeout cycle: normal release, no `TIMEOUT`.
- **Polarity**: an `HL` change alters `GNT` in the same cycle with no state effect.

## Structure
- Shared package `arb_pkg` holds:
  - state encoding (`IDLE`=1'b0, `GRANT`=1'b1);
  - constants `N_REQ`=4, `ID_W`=2, `HOLD_W`=8.
- Sub-module `dec_2_4_hl` (inputs `HL`, `EN`, `IN[1:0]`; output `OUT[3:0]`): combinational one-hot decoder.
  - `EN`=`GNT_VALID`, `IN`=`ID`.
  - Polarity from `HL`.
  - Full `case` with a default so no latch is inferred.
- Round-robin pick is a combinational rotate–priority–rotate over `REQ` and `PTR`. FSM, `PTR`, `ID`, `HOLD_CNT` and `TIMEOUT` are sequential with asynchronous reset.

## Test plan
- **Reset**: `RST`=1 with `HL`=1 then `HL`=0, `REQ`=1111 → `GNT`=0000 then 1111, `GNT_VALID`=0, `GNT_ID`=0. Asserting `RST` mid-grant clears `GNT` before the next edge.
- **Single request**: `EN`=1, `HL`=1, `REQ`=0100 at edge 0 → `GNT`=0100 and `GNT_ID`=2 from cycle 1. `DONE`=1 at edge 3 → `GNT`=0000 in cycle 4; next winner search starts at 3.
- **Fairness**: `REQ`=1111 held, `DONE` pulsed on each holder's second cycle → grant sequence 0,1,2,3,0, each grant 2 cycles, one `IDLE` cycle between grants.
- **Timeout**: `MAX_HOLD`=15, `REQ`=0010 held, `DONE`=0 → `GNT[1]` high exactly 15 cycles. `TIMEOUT`=1 for the one following `IDLE` cycle, then requester 1 is re-granted.
- **Enable revoke**: `EN`→0 while `ID`=2 with `REQ`=1111 → grant drops next cycle. `EN`→1 → requester 2 is granted again because `PTR` was unchanged.
- **Polarity and wrap**: `HL`=0 while `ID`=3 → `GNT`=0111. Release with `REQ`=1001 → next grant goes to requester 0 (`PTR` wrapped 3→0), `GNT`=1110.
